calc_operand_ctrl: RTL and testbench

CALC_OPERAND_CTRL -- requirements
Module: calc_operand_ctrl

---
 rtl/calc_pkg.sv | 13 +
 rtl/calc_flags.sv | 23 ++
 rtl/calc_operand_ctrl.sv | 103 ++++++++++
 tb/tb_calc_operand_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the operand-entry calculator controller.
package calc_pkg;

  localparam int CALC_W = 4;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/calc_flags.sv
// Combinational N/Z/C/V flag derivation from the adder operands and its returned sum/carry.
module calc_flags
  import calc_pkg::*;
#(
  parameter int N = CALC_W
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] sum,
  input  logic         cout,
  output logic         n,
  output logic         z,
  output logic         c,
  output logic         v
);

  assign n = sum[N-1];
  assign z = (sum == '0);
  assign c = cout;
  // Overflow: like-signed operands producing a sum of the opposite sign.
  assign v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/calc_operand_ctrl.sv
// Sequences A/B operand entry for an external adder and registers result plus flags.
// Result is valid two edges after B is entered; enter during EXEC is dropped.
module calc_operand_ctrl
  import calc_pkg::*;
#(
  parameter int N = CALC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enter,
  input  logic [N-1:0] data_in,
  input  logic         op_sub,
  output logic [N-1:0] adder_a,
  output logic [N-1:0] adder_b,
  output logic         adder_cin,
  input  logic [N-1:0] adder_sum,
  input  logic         adder_cout,
  output logic [N-1:0] result,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         result_valid,
  output logic [1:0]   state_o
);

  state_t       state_q;
  logic [N-1:0] reg_a_q;
  logic [N-1:0] reg_b_q;
  logic         reg_op_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  logic [3:0]   flags_d;
  logic         valid_q;

  assign adder_a   = reg_a_q;
  assign adder_b   = reg_op_q ? ~reg_b_q : reg_b_q;
  assign adder_cin = reg_op_q;

  calc_flags #(.N(N)) u_flags (
    .a    (adder_a),
    .b    (adder_b),
    .sum  (adder_sum),
    .cout (adder_cout),
    .n    (flags_d[3]),
    .z    (flags_d[2]),
    .c    (flags_d[1]),
    .v    (flags_d[0])
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q  <= WAIT_A;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      reg_op_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (enter) begin
            reg_a_q <= data_in;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (enter) begin
            reg_b_q  <= data_in;
            reg_op_q <= op_sub;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          result_q <= adder_sum;
          flags_q  <= flags_d;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          // Chained entry: a new A starts the next operation, old result is kept but marked stale.
          if (enter) begin
            reg_a_q <= data_in;
            valid_q <= 1'b0;
            state_q <= WAIT_B;
          end
        end
        default: state_q <= WAIT_A;
      endcase
    end
  end

  assign result       = result_q;
  assign flag_n       = flags_q[3];
  assign flag_z       = flags_q[2];
  assign flag_c       = flags_q[1];
  assign flag_v       = flags_q[0];
  assign result_valid = valid_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_calc_operand_ctrl.sv
// Self-checking bench: models the external adder and scoreboards each operation's result/flags.
module tb_calc_operand_ctrl;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] res;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, clear, enter, op_sub;
  logic [N-1:0] data_in;
  logic [N-1:0] adder_a, adder_b, adder_sum, result;
  logic         adder_cin, adder_cout;
  logic         flag_n, flag_z, flag_c, flag_v, result_valid;
  logic [1:0]   state_o;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{N{1'b0}}, adder_cin};

  calc_operand_ctrl #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .enter        (enter),
    .data_in      (data_in),
    .op_sub       (op_sub),
    .adder_a      (adder_a),
    .adder_b      (adder_b),
    .adder_cin    (adder_cin),
    .adder_sum    (adder_sum),
    .adder_cout   (adder_cout),
    .result       (result),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .result_valid (result_valid),
    .state_o      (state_o)
  );

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    exp_t e;
    logic [N-1:0] bb;
    logic [N:0]   s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, sub};
    e.res = s[N-1:0];
    e.n   = s[N-1];
    e.z   = (s[N-1:0] == 0);
    e.c   = s[N];
    e.v   = (a[N-1] == bb[N-1]) && (s[N-1] != a[N-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [N-1:0] d, input logic sub);
    enter   = 1'b1;
    data_in = d;
    op_sub  = sub;
    tick();
    enter = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({state_o, result, flag_n, flag_z, flag_c, flag_v, result_valid, adder_a, adder_b, adder_cin} !== '0) begin
      errors++;
      $display("FAIL %s_zero: state=%0d result=%0h nzcv=%b%b%b%b valid=%b a=%0h b=%0h cin=%b expected all zero",
               tag, state_o, result, flag_n, flag_z, flag_c, flag_v, result_valid, adder_a, adder_b, adder_cin);
    end
  endtask

  // Enter A then B, verify the two-edge latency, then pop and compare the scoreboard entry.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, input exp_t e);
    exp_t got, want;
    int   waited;
    press(a, 1'b0);
    press(b, sub);
    sb.push_back(e);
    tick();
    checks++;
    if (state_o !== 2'd3 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: state=%0d valid=%b expected state=3 valid=1 two edges after B", state_o, result_valid);
    end
    waited = 0;
    while (result_valid !== 1'b1 && waited < 4) begin
      tick();
      waited++;
    end
    want = sb.pop_front();
    got  = '{result, flag_n, flag_z, flag_c, flag_v};
    checks++;
    if (result_valid !== 1'b1 || got !== want) begin
      errors++;
      $display("FAIL op %0h%s%0h: got res=%0h nzcv=%b%b%b%b valid=%b expected res=%0h nzcv=%b%b%b%b",
               a, sub ? "-" : "+", b, got.res, got.n, got.z, got.c, got.v, result_valid,
               want.res, want.n, want.z, want.c, want.v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; enter = 1'b0; data_in = '0; op_sub = 1'b0;
    tick();
    tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_hold_state", 8'(state_o), 8'd0);
  endtask

  task automatic test_add();
    do_op(4'd3, 4'd4, 1'b0, '{4'd7, 1'b0, 1'b0, 1'b0, 1'b0});
    do_op(4'd7, 4'd1, 1'b0, '{4'd8, 1'b1, 1'b0, 1'b0, 1'b1});
    do_op(4'd9, 4'd8, 1'b0, '{4'd1, 1'b0, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic test_sub();
    do_op(4'd5, 4'd5, 1'b1, '{4'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    chk("sub_cin", 8'(adder_cin), 8'd1);
    chk("sub_b_inv", 8'(adder_b), 8'hA);
    do_op(4'd2, 4'd3, 1'b1, '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_enter_in_exec();
    press(4'd1, 1'b0);
    press(4'd2, 1'b0);
    sb.push_back(model(4'd1, 4'd2, 1'b0));
    enter = 1'b1; data_in = 4'd9;
    tick();
    enter = 1'b0;
    chk("exec_enter_state", 8'(state_o), 8'd3);
    chk("exec_enter_rega", 8'(adder_a), 8'd1);
    chk("exec_enter_result", 8'(result), 8'(sb.pop_front().res));
    tick();
    chk("done_hold_state", 8'(state_o), 8'd3);
    press(4'd6, 1'b0);
    chk("chain_state", 8'(state_o), 8'd1);
    chk("chain_rega", 8'(adder_a), 8'd6);
    chk("chain_valid", 8'(result_valid), 8'd0);
    chk("chain_result_held", 8'(result), 8'd3);
  endtask

  task automatic test_clear();
    clear = 1'b1; enter = 1'b1; data_in = 4'd5;
    tick();
    clear = 1'b0; enter = 1'b0;
    check_outputs_zero("clear");
  endtask

  task automatic test_reset_in_exec();
    press(4'd3, 1'b0);
    press(4'd4, 1'b1);
    chk("pre_reset_state", 8'(state_o), 8'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_outputs_zero("rst_exec");
    tick();
    chk("rst_exec_result", 8'(result), 8'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] a, b;
      logic         s;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      do_op(a, b, s, model(a, b, s));
    end
    chk("scoreboard_empty", 8'(sb.size()), 8'd0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_enter_in_exec();
    test_clear();
    test_reset_in_exec();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
